wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Writeback stage feeding the 32x32 register file's single write port (write/dr/wrData).
//  Merges two result sources:
//   - ALU results: always accepted, highest priority, no backpressure.
//   - Load/memory results: valid/ready handshake, buffered in a DEPTH-entry FIFO.
//  Drains one FIFO entry on every cycle the ALU is idle. Exports a pending-write check
//  so issue logic can stall on registers with an outstanding load.
// PARAMETERS
//  DEPTH  4   FIFO entries for memory results; power of 2, >= 2
//  AW     5   register address width (32 registers)
//  DW     32  data width
// PORTS
//  clk       in   1                  rising-edge clock
//  reset     in   1                  asynchronous, active-low (0 = in reset)
//  alu_valid in   1                  ALU result present this cycle
//  alu_dr    in   AW                 ALU destination register
//  alu_data  in   DW                 ALU result
//  mem_valid in   1                  memory result offered
//  mem_ready out  1                  FIFO can accept; push = mem_valid & mem_ready
//  mem_dr    in   AW                 memory destination register
//  mem_data  in   DW                 memory result
//  chk_reg   in   AW                 register queried for a pending write
//  pend_hit  out  1                  some valid FIFO entry targets chk_reg
//  count     out  $clog2(DEPTH+1)    current FIFO occupancy
//  write     out  1                  register file write enable (registered)
//  dr        out  AW                 register file destination (registered)
//  wrData    out  DW                 register file write data (registered)
// BEHAVIOUR
//  Reset (reset==0, async)
//   - write=0, dr=0, wrData=0, count=0; FIFO pointers cleared; entries discarded.
//   - mem_ready=0 while reset is low.
//   - Reset mid-drain drops all queued entries; no partial write is issued.
//  Per rising edge, with reset high
//   - alu_valid=1: write<=1, dr<=alu_dr, wrData<=alu_data; FIFO is not popped.
//   - else if count>0: pop head; write<=1, dr/wrData <= head entry.
//   - else: write<=0; dr and wrData hold their previous values.
//   - Push when mem_valid & mem_ready; the entry goes to the tail.
//   - Push and pop in the same cycle: count unchanged, both pointers advance.
//  Latency
//   - ALU result at edge N appears on write/dr/wrData after edge N; the register file
//     captures it at edge N+1.
//   - A pushed memory entry is poppable no earlier than the following edge (no
//     fall-through).
//  Handshake
//   - mem_ready = reset & (count < DEPTH), combinational from registered state.
//   - mem_ready does not look ahead to a same-cycle pop: a full FIFO refuses input even
//     while draining.
//   - mem_* inputs are ignored when mem_ready=0.
//  Ordering
//   - FIFO drains strictly in order.
//   - ALU may starve the FIFO indefinitely. Upstream must throttle ALU issue when count
//     is high.
//   - Upstream must not issue an ALU op whose destination has pend_hit=1. If it does,
//     the older load overwrites the newer result; this is flagged by a bench assertion,
//     not corrected in RTL.
//  Pointers and pend_hit
//   - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//   - Full/empty are decided from count only.
//   - pend_hit is combinational: OR over valid entries of (entry_dr==chk_reg).
//   - The entry being popped this cycle still counts; pend_hit drops after the pop edge.
// TESTING
//  1. Assert reset low mid-cycle -> write/dr/wrData/count go to 0 immediately;
//     mem_ready=0.
//  2. ALU dr=5, data=32'hDEADBEEF for one cycle -> next cycle write=1, dr=5,
//     wrData=DEADBEEF; the cycle after, write=0.
//  3. Same cycle: ALU dr=3/data=1 and mem push dr=7/data=2 -> write dr=3 first, then
//     dr=7/2; count 1->0.
//  4. DEPTH=4, ALU valid continuously, mem_valid held -> 4 pushes accepted, count=4,
//     mem_ready=0. Drop ALU -> 4 writes in push order, count 4,3,2,1,0.
//  5. Push dr=9, chk_reg=9 -> pend_hit=1 until the pop edge, then 0; chk_reg=8
//     -> pend_hit=0 throughout.
//  6. Exercise pointer wrap with 10 interleaved push/pop cycles at count 1-3 -> data
//     matches the scoreboard. Then pull reset low with count=3 -> count=0; no stale
//     write after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback merge of ALU results (priority, no stall) and buffered load results into the regfile write port.
// Latency: result sampled at edge N drives write/dr/wrData after edge N; queued loads pop no earlier than the edge after their push.
// Backpressure: ALU never stalls; mem_ready drops when the FIFO is full, with no look-ahead to a same-cycle pop.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alu_valid,
  input  logic [AW-1:0]                alu_dr,
  input  logic [DW-1:0]                alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [AW-1:0]                mem_dr,
  input  logic [DW-1:0]                mem_data,
  input  logic [AW-1:0]                chk_reg,
  output logic                         pend_hit,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         write,
  output logic [AW-1:0]                dr,
  output logic [DW-1:0]                wrData
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // FIFO storage and bookkeeping; full/empty come from the occupancy counter only
  logic [AW-1:0]  ent_dr   [DEPTH];
  logic [DW-1:0]  ent_data [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count_q;
  logic [PW-1:0]  ent_off  [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic           push;
  logic           pop;

  // Ready is held low through reset so nothing is accepted while state is being cleared
  assign mem_ready = reset & (count_q < CW'(DEPTH));
  assign push      = mem_valid & mem_ready;
  // The ALU owns the write port whenever it has a result; the FIFO only drains in idle cycles
  assign pop       = ~alu_valid & (count_q != '0);
  assign count     = count_q;

  // Mark live slots: a slot is valid if its distance from the head is below the occupancy
  always_comb begin
    ent_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_off[i] = PW'(i) - rd_ptr;
      ent_vld[i] = (CW'(ent_off[i]) < count_q);
    end
  end

  // Pending-write lookup; the entry popping this cycle is still live until the edge
  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_dr[i] == chk_reg)) begin
        pend_hit = 1'b1;
      end
    end
  end

  // Pointer and occupancy update; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload capture at the tail; stale contents are harmless because validity comes from count
  always_ff @(posedge clk) begin
    if (push) begin
      ent_dr[wr_ptr]   <= mem_dr;
      ent_data[wr_ptr] <= mem_data;
    end
  end

  // Registered write port: ALU first, else FIFO head, else idle with dr/wrData held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write  <= 1'b0;
      dr     <= '0;
      wrData <= '0;
    end else if (alu_valid) begin
      write  <= 1'b1;
      dr     <= alu_dr;
      wrData <= alu_data;
    end else if (pop) begin
      write  <= 1'b1;
      dr     <= ent_dr[rd_ptr];
      wrData <= ent_data[rd_ptr];
    end else begin
      write  <= 1'b0;
    end
  end

endmodule
